// File: rtl/aes_block_assembler.sv
// Purpose : packs WORD_W-bit beats into 128-bit row-major blocks (byte 0 in [127:120]),
//           zero-pads a short final block and reports valid bytes at one-beat granularity.
// Latency : block registered on the edge that accepts its completing beat; 1 beat/clk when m_ready=1.
// Backpr. : s_ready = ~m_valid | m_ready; the held block stays stable until it is drained.
// Option  : define AES_ASM_TRANSPOSE_EN to register m_block in column order (output byte 4a+b
//           = assembled byte 4b+a). Padding is applied first and no latency is added.
module aes_block_assembler #(
  parameter int WORD_W = 32  // 8, 16 or 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  output logic [127:0]      m_block,
  output logic [4:0]        m_nbytes,
  output logic              m_last,
  output logic              m_valid,
  input  logic              m_ready
);

  localparam int BEATS       = 128 / WORD_W;
  localparam int CNT_W       = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int BYTES_PER_B = WORD_W / 8;

  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(BEATS - 1);

  // Beat position inside the block being assembled and the partial block itself.
  logic [CNT_W-1:0] beat_cnt;
  logic [127:0]     asm_reg;

  // Handshake decode.
  logic beat_fire;
  logic completing;
  logic drain;

  // Next-state views of the assembly register and the outgoing block.
  logic [127:0] asm_ins;
  logic [127:0] keep_mask;
  logic [127:0] blk_padded;
  logic [127:0] blk_out;
  logic [4:0]   nbytes_next;

  // Output byte 4a+b takes assembled byte 4b+a: rows become columns.
  function automatic logic [127:0] col_order(input logic [127:0] r);
    logic [127:0] c;
    c = '0;
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        c[127 - 8*(4*a + b) -: 8] = r[127 - 8*(4*b + a) -: 8];
      end
    end
    return c;
  endfunction

  // Input may advance whenever there is no held block or the held block leaves this cycle.
  assign s_ready    = ~m_valid | m_ready;
  assign beat_fire  = s_valid & s_ready;
  assign completing = (beat_cnt == LAST_SLOT) | s_last;
  assign drain      = m_valid & m_ready;

  // Insert the current beat into its slot; beat 0 occupies the most significant word.
  always_comb begin
    int slot_lo;
    asm_ins = asm_reg;
    slot_lo = 128 - (int'(beat_cnt) + 1) * WORD_W;
    asm_ins[slot_lo +: WORD_W] = s_data;
  end

  // Clear every slot after the completing beat so a short block is always zero-padded,
  // independent of whatever the assembly register happens to hold below the write point.
  always_comb begin
    logic [127:0] ones;
    int           shamt;
    ones      = '1;
    shamt     = (int'(beat_cnt) + 1) * WORD_W;
    keep_mask = ~(ones >> shamt);
    blk_padded = asm_ins & keep_mask;
  end

  // Select the register ordering of the outgoing block.
`ifdef AES_ASM_TRANSPOSE_EN
  assign blk_out = col_order(blk_padded);
`else
  assign blk_out = blk_padded;
`endif

  // Byte count reported with the block: whole beats only.
  assign nbytes_next = 5'((int'(beat_cnt) + 1) * BYTES_PER_B);

  // Assembly state: advance on every accepted beat, restart after a completing beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_cnt <= '0;
      asm_reg  <= '0;
    end else if (beat_fire) begin
      if (completing) begin
        beat_cnt <= '0;
        asm_reg  <= '0;
      end else begin
        beat_cnt <= beat_cnt + 1'b1;
        asm_reg  <= asm_ins;
      end
    end
  end

  // Output register: load on a completing beat (replacing a block drained in the same
  // cycle), clear valid on a plain drain, otherwise hold everything stable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_block  <= '0;
      m_nbytes <= '0;
      m_last   <= 1'b0;
      m_valid  <= 1'b0;
    end else if (beat_fire && completing) begin
      m_block  <= blk_out;
      m_nbytes <= nbytes_next;
      m_last   <= s_last;
      m_valid  <= 1'b1;
    end else if (drain) begin
      m_valid  <= 1'b0;
    end
  end

endmodule
